ecc_scrub_ctrl: RTL and testbench

Background scrubber/controller for a 172-bit ECC-protected memory that sits beside the functional port and an external ECC decode/fault-detect instance. It walks all addresses, reads each word, and checks it through the decoder. Single-bit errors are written back corrected via the external encoder. It keeps saturating error statistics and raises a sticky interrupt on uncorrectable or checker-fault events. The functional port always has priority; the scrubber only uses idle memory cycles.

---
 rtl/ecc_scrub_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: walks all words in idle memory cycles, writes back single-bit corrections.
// Define ECC_SCRUB_ERR_LOG_EN to latch the first uncorrectable address into err_addr/err_valid.
//
// state | meaning
// IDLE  | scrubbing disabled, address retained
// WAIT  | idle gap between passes
// READ  | issue read when the functional port is idle
// CHECK | read data and decoder flags valid
// WB    | write back corrected word when the functional port is idle
// NEXT  | advance/wrap address, end-of-pass handling
module ecc_scrub_ctrl #(
    parameter int DATA_WIDTH   = 172,
    parameter int PARITY_WIDTH = 9,
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 64,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scrub_en,
    input  logic [15:0]             scrub_interval,
    input  logic                    cnt_clr,
    input  logic                    func_req,
    input  logic                    func_wr,
    input  logic [ADDR_WIDTH-1:0]   func_addr,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [PARITY_WIDTH-1:0] mem_wr_parity,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    input  logic [PARITY_WIDTH-1:0] mem_rd_parity,
    output logic [DATA_WIDTH-1:0]   dec_data_in,
    output logic [PARITY_WIDTH-1:0] dec_parity_in,
    input  logic [DATA_WIDTH-1:0]   dec_data_out,
    input  logic                    dec_sbit_err,
    input  logic                    dec_dbit_err,
    input  logic                    dec_ecc_fault,
    output logic [DATA_WIDTH-1:0]   enc_data,
    input  logic [PARITY_WIDTH-1:0] enc_parity,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    scrub_irq,
    output logic                    pass_done,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_valid
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CHECK, S_WB, S_NEXT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [15:0]             wait_cnt;
    logic [DATA_WIDTH-1:0]   corr_data;
    logic                    hazard;
    logic                    in_check;
    logic                    sbit_ev;
    logic                    dbit_ev;
    logic                    fault_ev;
    logic                    unc_ev;

    // A functional write to the word being scrubbed makes our corrected copy stale.
    assign hazard   = func_req & func_wr & (func_addr == addr);
    assign in_check = (state == S_CHECK);
    assign sbit_ev  = in_check & dec_sbit_err & ~dec_dbit_err & ~dec_ecc_fault;
    assign dbit_ev  = in_check & dec_dbit_err;
    assign fault_ev = in_check & dec_ecc_fault;
    assign unc_ev   = dbit_ev | fault_ev;

    assign mem_rd_en     = (state == S_READ) & ~func_req;
    assign mem_wr_en     = (state == S_WB) & ~func_req;
    assign mem_addr      = addr;
    assign mem_wr_data   = corr_data;
    assign enc_data      = corr_data;
    assign mem_wr_parity = (state == S_WB) ? enc_parity : '0;
    assign dec_data_in   = mem_rd_data;
    assign dec_parity_in = mem_rd_parity;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            wait_cnt  <= '0;
            corr_data <= '0;
            pass_done <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                S_IDLE:  if (scrub_en) state <= S_READ;
                S_WAIT: begin
                    if (!scrub_en)          state <= S_IDLE;
                    else if (wait_cnt == '0) state <= S_READ;
                    else                    wait_cnt <= wait_cnt - 16'd1;
                end
                S_READ:  if (!func_req) state <= S_CHECK;
                S_CHECK: begin
                    if (sbit_ev && !hazard) begin
                        corr_data <= dec_data_out;
                        state     <= S_WB;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_WB:    if (hazard || !func_req) state <= S_NEXT;
                S_NEXT: begin
                    if (addr == LAST_ADDR) begin
                        addr      <= '0;
                        pass_done <= 1'b1;
                        wait_cnt  <= scrub_interval;
                        state     <= scrub_en ? S_WAIT : S_IDLE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= scrub_en ? S_READ : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A clear coinciding with an event leaves that event counted.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] c,
                                                      input logic ev, input logic clr);
        if (clr)                    return ev ? CNT_WIDTH'(1) : '0;
        else if (ev && c != CNT_MAX) return c + 1'b1;
        else                        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbit_cnt  <= '0;
            dbit_cnt  <= '0;
            fault_cnt <= '0;
            scrub_irq <= 1'b0;
        end else begin
            sbit_cnt  <= cnt_next(sbit_cnt, sbit_ev, cnt_clr);
            dbit_cnt  <= cnt_next(dbit_cnt, dbit_ev, cnt_clr);
            fault_cnt <= cnt_next(fault_cnt, fault_ev, cnt_clr);
            scrub_irq <= cnt_clr ? unc_ev : (scrub_irq | unc_ev);
        end
    end

`ifdef ECC_SCRUB_ERR_LOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr  <= '0;
            err_valid <= 1'b0;
        end else if (cnt_clr) begin
            err_valid <= unc_ev;
            if (unc_ev) err_addr <= addr;
        end else if (unc_ev && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= addr;
        end
    end
`else
    assign err_addr  = '0;
    assign err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: memory/decoder/encoder models plus a write-back scoreboard.
module tb_ecc_scrub_ctrl;
    localparam int DW = 172, PW = 9, AW = 6, DEPTH = 64, CW = 8;
    localparam logic [DW-1:0] FLIP = 172'd1;
    localparam logic [PW-1:0] PMASK = 9'h1A5;

    logic clk = 1'b0, rst;
    logic scrub_en, cnt_clr, func_req, func_wr;
    logic [15:0] scrub_interval;
    logic [AW-1:0] func_addr;
    logic mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data, dec_data_in, dec_data_out, enc_data;
    logic [PW-1:0] mem_wr_parity, mem_rd_parity, dec_parity_in, enc_parity;
    logic dec_sbit_err, dec_dbit_err, dec_ecc_fault;
    logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
    logic scrub_irq, pass_done, busy, err_valid;
    logic [AW-1:0] err_addr;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int t0, t1, t2;

    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] mem_p [DEPTH];
    logic [1:0]    etype [DEPTH];   // 0 clean, 1 sbit, 2 dbit, 3 checker fault
    logic [AW-1:0] rd_addr_q = '0;
    logic          rd_v_q = 1'b0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [PW-1:0] p; } exp_t;
    exp_t exp_q[$];

    ecc_scrub_ctrl dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
        .cnt_clr(cnt_clr), .func_req(func_req), .func_wr(func_wr), .func_addr(func_addr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_parity(mem_wr_parity),
        .mem_rd_data(mem_rd_data), .mem_rd_parity(mem_rd_parity),
        .dec_data_in(dec_data_in), .dec_parity_in(dec_parity_in), .dec_data_out(dec_data_out),
        .dec_sbit_err(dec_sbit_err), .dec_dbit_err(dec_dbit_err), .dec_ecc_fault(dec_ecc_fault),
        .enc_data(enc_data), .enc_parity(enc_parity),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
        .scrub_irq(scrub_irq), .pass_done(pass_done), .busy(busy),
        .err_addr(err_addr), .err_valid(err_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_v_q <= mem_rd_en;
        if (mem_rd_en) begin
            mem_rd_data   <= mem_d[mem_addr];
            mem_rd_parity <= mem_p[mem_addr];
            rd_addr_q     <= mem_addr;
        end
    end

    assign dec_sbit_err  = rd_v_q && (etype[rd_addr_q] == 2'd1);
    assign dec_dbit_err  = rd_v_q && (etype[rd_addr_q] == 2'd2);
    assign dec_ecc_fault = rd_v_q && (etype[rd_addr_q] == 2'd3);
    assign dec_data_out  = dec_sbit_err ? (dec_data_in ^ FLIP) : dec_data_in;
    assign enc_parity    = enc_data[PW-1:0] ^ PMASK;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.a = AW'(a);
        e.d = mem_d[a] ^ FLIP;
        e.p = e.d[PW-1:0] ^ PMASK;
        exp_q.push_back(e);
    endtask

    // Scoreboard and bus-priority monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en || mem_wr_en) chk("strobe_during_func_req", func_req, 1'b0);
            if (mem_wr_en) begin
                chk("write_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_addr", mem_addr, e.a);
                    chk("wb_data", mem_wr_data, e.d);
                    chk("wb_parity", mem_wr_parity, e.p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pass(input int lim);
        int n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < lim);
        chk("wait_pass_done", pass_done, 1'b1);
    endtask

    task automatic wait_rd(input int a, input int lim);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(mem_rd_en && mem_addr == AW'(a)) && n < lim);
        chk("wait_read", mem_rd_en && mem_addr == AW'(a), 1'b1);
    endtask

    initial begin
        rst = 1'b1; scrub_en = 1'b0; cnt_clr = 1'b0; func_req = 1'b0; func_wr = 1'b0;
        func_addr = '0; scrub_interval = 16'd10;
        for (int i = 0; i < DEPTH; i++) begin
            logic [191:0] w;
            w = '0;
            for (int k = 0; k < 6; k++) w = {w[159:0], 32'($urandom)};
            mem_d[i] = w[DW-1:0];
            mem_p[i] = PW'($urandom);
            etype[i] = 2'd0;
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pass_done", pass_done, 1'b0);
        chk("rst_irq", scrub_irq, 1'b0);
        chk("rst_sbit_cnt", sbit_cnt, 0);
        chk("rst_wr_data", mem_wr_data, 0);

        step(); rst = 1'b0; scrub_en = 1'b1;

        // Clean passes: 64*3 word cycles + 11 wait cycles.
        wait_pass(1000); t0 = cyc;
        chk("busy_running", busy, 1'b1);
        wait_pass(1000); t1 = cyc;
        chk("clean_period", t1 - t0, 203);
        chk("clean_sbit_cnt", sbit_cnt, 0);
        chk("clean_dbit_cnt", dbit_cnt, 0);
        chk("clean_irq", scrub_irq, 1'b0);

        // Single-bit error at 5: one corrected write-back.
        etype[5] = 2'd1; push_exp(5); t0 = cyc;
        wait_pass(1000); t1 = cyc; etype[5] = 2'd0;
        chk("sbit_period", t1 - t0, 204);
        chk("sbit_cnt_1", sbit_cnt, 1);
        chk("sbit_irq", scrub_irq, 1'b0);
        chk("sbit_queue_drained", exp_q.size(), 0);

        // Double-bit error at 9, then checker fault at 12.
        etype[9] = 2'd2; t0 = cyc;
        wait_pass(1000); t1 = cyc; etype[9] = 2'd0;
        chk("dbit_period", t1 - t0, 203);
        chk("dbit_cnt_1", dbit_cnt, 1);
        chk("dbit_irq", scrub_irq, 1'b1);
`ifdef ECC_SCRUB_ERR_LOG_EN
        chk("err_valid_9", err_valid, 1'b1);
        chk("err_addr_9", err_addr, 9);
`else
        chk("err_valid_off", err_valid, 1'b0);
        chk("err_addr_off", err_addr, 0);
`endif
        etype[12] = 2'd3;
        wait_pass(1000); etype[12] = 2'd0;
        chk("fault_cnt_1", fault_cnt, 1);
        chk("fault_dbit_unchanged", dbit_cnt, 1);
`ifdef ECC_SCRUB_ERR_LOG_EN
        chk("err_addr_kept", err_addr, 9);
`endif

        // Functional port holds READ and WB of addr 20 for 7 cycles each.
        etype[20] = 2'd1; push_exp(20); t0 = cyc;
        wait_rd(19, 500);
        step(); step(); step();
        func_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); chk("hold_read_no_rd", mem_rd_en, 1'b0); step();
        end
        func_req = 1'b0;
        @(negedge clk);
        chk("resume_read", {mem_rd_en, mem_addr}, {1'b1, 6'd20});
        step(); step();
        func_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); chk("hold_wb_no_wr", mem_wr_en, 1'b0); step();
        end
        func_req = 1'b0;
        @(negedge clk);
        chk("resume_wb", {mem_wr_en, mem_addr}, {1'b1, 6'd20});
        etype[20] = 2'd0;
        wait_pass(1000); t1 = cyc;
        chk("collision_period", t1 - t0, 218);
        chk("sbit_cnt_2", sbit_cnt, 2);

        // Functional write to addr 5 during its WB cancels the write-back.
        etype[5] = 2'd1;
        wait_rd(5, 500);
        step(); step();
        func_req = 1'b1; func_wr = 1'b1; func_addr = 6'd5;
        @(negedge clk); chk("hazard_no_wr", mem_wr_en, 1'b0);
        step();
        func_req = 1'b0; func_wr = 1'b0; func_addr = '0;
        step();
        @(negedge clk);
        chk("hazard_next_addr", {mem_rd_en, mem_addr}, {1'b1, 6'd6});
        etype[5] = 2'd0;
        chk("sbit_cnt_3", sbit_cnt, 3);

        // scrub_interval = 0: WAIT lasts a single cycle.
        wait_pass(1000);
        scrub_interval = 16'd0;
        wait_pass(1000); t1 = cyc;
        wait_pass(1000); t2 = cyc;
        chk("interval0_period", t2 - t1, 193);

        // 320 single-bit events saturate the 8-bit counter.
        for (int p = 0; p < 5; p++)
            for (int i = 0; i < DEPTH; i++) push_exp(i);
        for (int i = 0; i < DEPTH; i++) etype[i] = 2'd1;
        for (int p = 0; p < 5; p++) wait_pass(2000);
        for (int i = 0; i < DEPTH; i++) etype[i] = 2'd0;
        chk("sbit_saturated", sbit_cnt, 255);
        chk("sat_queue_drained", exp_q.size(), 0);

        // cnt_clr coincident with events.
        etype[30] = 2'd1; push_exp(30); etype[40] = 2'd2;
        wait_rd(30, 500);
        step(); cnt_clr = 1'b1;
        step(); cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_sbit_cnt", sbit_cnt, 1);
        chk("clr_dbit_cnt", dbit_cnt, 0);
        chk("clr_fault_cnt", fault_cnt, 0);
        chk("clr_irq", scrub_irq, 1'b0);
        chk("clr_err_valid", err_valid, 1'b0);
        etype[30] = 2'd0;
        wait_rd(40, 100);
        step(); cnt_clr = 1'b1;
        step(); cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_dbit_event", dbit_cnt, 1);
        chk("clr_dbit_irq", scrub_irq, 1'b1);
`ifdef ECC_SCRUB_ERR_LOG_EN
        chk("clr_err_addr_40", {err_valid, err_addr}, {1'b1, 6'd40});
`endif
        etype[40] = 2'd0;

        // Asynchronous reset in the middle of a write-back.
        etype[50] = 2'd1;
        wait_rd(50, 100);
        step(); step();
        chk("wb_before_reset", mem_wr_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_wr_en", mem_wr_en, 1'b0);
        chk("arst_rd_en", mem_rd_en, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wr_data", mem_wr_data, 0);
        chk("arst_wr_parity", mem_wr_parity, 0);
        chk("arst_cnts", {sbit_cnt, dbit_cnt, fault_cnt}, 0);
        chk("arst_flags", {scrub_irq, pass_done, err_valid, err_addr}, 0);
        etype[50] = 2'd0;
        repeat (2) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
